// File: rtl/mem_stream_reader_pkg.sv
// Shared state encoding and parameter checks for the memory stream read engines.
package mem_stream_reader_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        DRAIN = ST_DRAIN
    } readStateT;

    function automatic bit latencyOk(input int lat);
        return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/mem_stream_lat_pipe.sv
// Valid shift register that tracks outstanding fixed-latency reads; tailOut rises DEPTH cycles
// after validIn, emptyOut is low while any read is in flight, and the block never stalls.
module mem_stream_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clkIn,
    input  logic rstIn,
    input  logic validIn,
    output logic tailOut,
    output logic emptyOut
);

    logic [DEPTH-1:0] pipe;

    generate
        if (DEPTH == 1) begin : gSingle
            always_ff @(posedge clkIn or posedge rstIn) begin
                if (rstIn) begin
                    pipe <= '0;
                end else begin
                    pipe <= validIn;
                end
            end
        end else begin : gShift
            always_ff @(posedge clkIn or posedge rstIn) begin
                if (rstIn) begin
                    pipe <= '0;
                end else begin
                    pipe <= {pipe[DEPTH-2:0], validIn};
                end
            end
        end
    endgenerate

    assign tailOut  = pipe[DEPTH-1];
    assign emptyOut = ~|pipe;

endmodule

// File: rtl/mem_stream_reader.sv
// Command-driven burst reader: sequential sync-RAM reads pushed into a downstream FIFO, strobe to
// dataValidOut is READ_LATENCY+1 cycles; dataReadyIn gates issue only, so in-flight words still land.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int LEN_WIDTH    = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic [ADDR_WIDTH-1:0] cmdAddrIn,
    input  logic [LEN_WIDTH-1:0]  cmdLenIn,
    input  logic                  cmdValidIn,
    output logic                  cmdReadyOut,
    output logic [ADDR_WIDTH-1:0] memAddrOut,
    output logic                  memRdEnOut,
    input  logic [DATA_WIDTH-1:0] memDataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValidOut,
    input  logic                  dataReadyIn,
    output logic                  busyOut,
    output logic                  doneOut
);

    generate
        if (!latencyOk(READ_LATENCY)) begin : gBadLatency
            $error("mem_stream_reader: READ_LATENCY must be in 1..4");
        end
    endgenerate

    readStateT             state;
    logic [ADDR_WIDTH-1:0] curAddr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  issueNow;
    logic                  lastIssue;
    logic                  pipeTail;
    logic                  pipeEmpty;

    // The FIFO's ready is registered on its side, so sampling it here keeps issue in the same cycle.
    assign issueNow   = (state == ISSUE) && dataReadyIn;
    assign lastIssue  = issueNow && (remaining == LEN_WIDTH'(1));
    assign memRdEnOut = issueNow;
    assign memAddrOut = curAddr;

    mem_stream_lat_pipe #(
        .DEPTH(READ_LATENCY)
    ) uLatPipe (
        .clkIn   (clkIn),
        .rstIn   (rstIn),
        .validIn (issueNow),
        .tailOut (pipeTail),
        .emptyOut(pipeEmpty)
    );

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state       <= IDLE;
            cmdReadyOut <= 1'b0;
            busyOut     <= 1'b0;
            doneOut     <= 1'b0;
            curAddr     <= '0;
            remaining   <= '0;
        end else begin
            doneOut <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmdValidIn && cmdReadyOut) begin
                        cmdReadyOut <= 1'b0;
                        busyOut     <= 1'b1;
                        curAddr     <= cmdAddrIn;
                        remaining   <= cmdLenIn;
                        state       <= (cmdLenIn != '0) ? ISSUE : DRAIN;
                    end else begin
                        // Held low through the done cycle, so bursts are separated by one idle cycle.
                        cmdReadyOut <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (issueNow) begin
                        curAddr   <= curAddr + ADDR_WIDTH'(1);
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (lastIssue) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // An empty pipe means the last capture has already been made into dataOut.
                    if (pipeEmpty) begin
                        state   <= IDLE;
                        busyOut <= 1'b0;
                        doneOut <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            dataOut      <= '0;
            dataValidOut <= 1'b0;
        end else begin
            dataValidOut <= pipeTail;
            if (pipeTail) begin
                dataOut <= memDataIn;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Drives two reader instances (READ_LATENCY 1 and 2) through directed bursts and checks them
// against a cycle-stamped queue model plus hand-computed expectations.
module tb_mem_stream_reader;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cmdAddr = '0;
    logic [LW-1:0] cmdLen = '0;
    logic          cmdValid = 1'b0;
    logic          dataReady = 1'b1;
    logic          sel = 1'b0;

    logic          cmdValid1, cmdReady1, memRdEn1, dataValid1, busy1, done1;
    logic [AW-1:0] memAddr1;
    logic [DW-1:0] memData1, dataOut1;
    logic          cmdValid2, cmdReady2, memRdEn2, dataValid2, busy2, done2;
    logic [AW-1:0] memAddr2;
    logic [DW-1:0] memData2, dataOut2;

    assign cmdValid1 = cmdValid & ~sel;
    assign cmdValid2 = cmdValid & sel;

    mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .READ_LATENCY(1)) dut1 (
        .clkIn(clk), .rstIn(rst), .cmdAddrIn(cmdAddr), .cmdLenIn(cmdLen), .cmdValidIn(cmdValid1),
        .cmdReadyOut(cmdReady1), .memAddrOut(memAddr1), .memRdEnOut(memRdEn1), .memDataIn(memData1),
        .dataOut(dataOut1), .dataValidOut(dataValid1), .dataReadyIn(dataReady), .busyOut(busy1),
        .doneOut(done1)
    );

    mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .READ_LATENCY(2)) dut2 (
        .clkIn(clk), .rstIn(rst), .cmdAddrIn(cmdAddr), .cmdLenIn(cmdLen), .cmdValidIn(cmdValid2),
        .cmdReadyOut(cmdReady2), .memAddrOut(memAddr2), .memRdEnOut(memRdEn2), .memDataIn(memData2),
        .dataOut(dataOut2), .dataValidOut(dataValid2), .dataReadyIn(dataReady), .busyOut(busy2),
        .doneOut(done2)
    );

    logic          cmdReadyM, memRdEnM, dataValidM, busyM, doneM;
    logic [AW-1:0] memAddrM;
    logic [DW-1:0] dataOutM;
    assign cmdReadyM  = sel ? cmdReady2  : cmdReady1;
    assign memRdEnM   = sel ? memRdEn2   : memRdEn1;
    assign memAddrM   = sel ? memAddr2   : memAddr1;
    assign dataValidM = sel ? dataValid2 : dataValid1;
    assign dataOutM   = sel ? dataOut2   : dataOut1;
    assign busyM      = sel ? busy2      : busy1;
    assign doneM      = sel ? done2      : done1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] memVal(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    // Synchronous RAMs; unread cycles return a poison word.
    logic [DW-1:0] ram1q, ram2a, ram2b;
    always @(posedge clk) begin
        ram1q <= memRdEn1 ? memVal(memAddr1) : 32'hDEADBEEF;
        ram2a <= memRdEn2 ? memVal(memAddr2) : 32'hDEADBEEF;
        ram2b <= ram2a;
    end
    assign memData1 = ram1q;
    assign memData2 = ram2b;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observation logs used by the hand-computed checks.
    int            strobeCyc[$];
    logic [AW-1:0] strobeAddr[$];
    int            validCyc[$];
    logic [DW-1:0] validDat[$];
    int            doneLog[$];
    int            acceptLog[$];
    int            busyCount = 0;

    task automatic clearLogs();
        strobeCyc.delete(); strobeAddr.delete(); validCyc.delete(); validDat.delete();
        doneLog.delete(); acceptLog.delete(); busyCount = 0;
    endtask

    typedef struct {
        int            cyc;
        logic [DW-1:0] dat;
    } expWordT;

    expWordT       expQ[$];
    bit            mIssuing = 1'b0;
    bit            mHasBurst = 1'b0;
    bit            skipReady = 1'b1;
    logic [AW-1:0] mAddr;
    logic [LW-1:0] mRem;
    int            mBusyFrom = 0;
    int            mDoneCyc = 0;

    always @(negedge clk) begin : compare
        bit      expRdEn, expValid, expBusy, expDone, expReady;
        int      rl;
        expWordT w;
        rl = sel ? 2 : 1;
        if (rst) begin
            check("rst_cmdReady", cmdReadyM, 0);
            check("rst_memRdEn", memRdEnM, 0);
            check("rst_memAddr", memAddrM, 0);
            check("rst_dataValid", dataValidM, 0);
            check("rst_dataOut", dataOutM, 0);
            check("rst_busy", busyM, 0);
            check("rst_done", doneM, 0);
            expQ.delete();
            mIssuing = 1'b0;
            mHasBurst = 1'b0;
            skipReady = 1'b1;
        end else begin
            expRdEn  = mIssuing && dataReady;
            expValid = (expQ.size() > 0) && (expQ[0].cyc == cyc);
            expBusy  = mHasBurst && (cyc >= mBusyFrom) && (cyc < mDoneCyc);
            expDone  = mHasBurst && (cyc == mDoneCyc);
            expReady = !expBusy && !expDone;
            check("memRdEn", memRdEnM, expRdEn);
            if (expRdEn) check("memAddr", memAddrM, mAddr);
            check("dataValid", dataValidM, expValid);
            if (expValid) check("dataOut", dataOutM, expQ[0].dat);
            check("busy", busyM, expBusy);
            check("done", doneM, expDone);
            if (!skipReady) check("cmdReady", cmdReadyM, expReady);
            skipReady = 1'b0;

            if (memRdEnM) begin strobeCyc.push_back(cyc); strobeAddr.push_back(memAddrM); end
            if (dataValidM) begin validCyc.push_back(cyc); validDat.push_back(dataOutM); end
            if (doneM) doneLog.push_back(cyc);
            if (busyM) busyCount++;
            if (cmdValid && cmdReadyM) acceptLog.push_back(cyc);

            if (expRdEn) begin
                w.cyc = cyc + rl + 1;
                w.dat = memVal(mAddr);
                expQ.push_back(w);
                mAddr = mAddr + 16'd1;
                mRem  = mRem - 16'd1;
                if (mRem == 0) begin
                    mIssuing = 1'b0;
                    mDoneCyc = cyc + rl + 2;
                end
            end
            if (expValid) void'(expQ.pop_front());
            if (expDone) mHasBurst = 1'b0;
            if (cmdValid && expReady) begin
                mHasBurst = 1'b1;
                mBusyFrom = cyc + 1;
                mAddr     = cmdAddr;
                mRem      = cmdLen;
                mIssuing  = (cmdLen != 0);
                mDoneCyc  = (cmdLen == 0) ? cyc + 2 : 32'h7fffffff;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [AW-1:0] a, input logic [LW-1:0] n);
        bit ok;
        ok = 1'b0;
        cmdAddr = a;
        cmdLen = n;
        cmdValid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk); #1;
            ok = cmdReadyM;
            @(posedge clk); #1;
        end
        cmdValid = 1'b0;
        check("cmd_accepted", ok, 1);
    endtask

    task automatic waitDone(input int n);
        for (int i = 0; i < 300 && doneLog.size() < n; i++) begin
            @(negedge clk); #1;
        end
        check("done_seen", doneLog.size() >= n, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        int inWindow;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        // Basic burst, READ_LATENCY 1
        sel = 1'b0;
        clearLogs(); sendCmd(16'h0010, 4); waitDone(1); idle(2);
        check("basic_strobes", strobeCyc.size(), 4);
        check("basic_addr0", strobeAddr[0], 16'h0010);
        check("basic_addr3", strobeAddr[3], 16'h0013);
        check("basic_strobe_span", strobeCyc[3] - strobeCyc[0], 3);
        check("basic_latency", validCyc[0] - strobeCyc[0], 2);
        check("basic_words", validDat.size(), 4);
        check("basic_dat0", validDat[0], 32'hFFEF0010);
        check("basic_dat3", validDat[3], 32'hFFEC0013);
        check("basic_done_gap", doneLog[0] - validCyc[3], 1);

        // Zero length
        clearLogs(); sendCmd(16'h0055, 0); waitDone(1); idle(2);
        check("zero_strobes", strobeCyc.size(), 0);
        check("zero_words", validDat.size(), 0);
        check("zero_done_delay", doneLog[0] - acceptLog[0], 2);
        check("zero_busy_cycles", busyCount, 1);

        // Address wrap
        clearLogs(); sendCmd(16'hFFFE, 4); waitDone(1); idle(2);
        check("wrap_addr0", strobeAddr[0], 16'hFFFE);
        check("wrap_addr1", strobeAddr[1], 16'hFFFF);
        check("wrap_addr2", strobeAddr[2], 16'h0000);
        check("wrap_addr3", strobeAddr[3], 16'h0001);
        check("wrap_dat2", validDat[2], 32'hFFFF0000);
        check("wrap_dat3", validDat[3], 32'hFFFE0001);

        // Backpressure, READ_LATENCY 2: ready low for burst cycles 3..6
        sel = 1'b1;
        idle(2);
        clearLogs(); sendCmd(16'h0100, 8);
        for (int c = 1; c <= 12; c++) begin
            dataReady = !(c >= 3 && c <= 6);
            @(posedge clk); #1;
        end
        dataReady = 1'b1;
        waitDone(1); idle(2);
        check("bp_strobes", strobeCyc.size(), 8);
        check("bp_resume_addr", strobeAddr[2], 16'h0102);
        check("bp_resume_gap", strobeCyc[2] - strobeCyc[1], 5);
        check("bp_words", validDat.size(), 8);
        check("bp_dat7", validDat[7], 32'hFEF80107);
        inWindow = 0;
        foreach (validCyc[i])
            if (validCyc[i] >= strobeCyc[0] + 2 && validCyc[i] <= strobeCyc[0] + 5) inWindow++;
        check("bp_skid_words", inWindow, 2);
        check("bp_done_count", doneLog.size(), 1);

        // Back-to-back with the second command held during the first burst
        clearLogs(); sendCmd(16'h0020, 3); sendCmd(16'h0040, 2); waitDone(2); idle(2);
        check("b2b_accept_gap", acceptLog[1] - doneLog[0], 1);
        check("b2b_strobe_gap", strobeCyc[3] - doneLog[0], 2);
        check("b2b_words", validDat.size(), 5);
        check("b2b_dat3", validDat[3], 32'hFFBF0040);

        // Reset mid-burst
        clearLogs(); sendCmd(16'h0300, 10);
        for (int i = 0; i < 100 && strobeCyc.size() < 3; i++) begin
            @(negedge clk); #1;
        end
        check("rst_pre_strobes", strobeCyc.size(), 3);
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(4);
        check("rst_no_done", doneLog.size(), 0);
        check("rst_strobe_total", strobeCyc.size(), 3);
        clearLogs(); sendCmd(16'h0400, 3); waitDone(1); idle(2);
        check("post_rst_addr0", strobeAddr[0], 16'h0400);
        check("post_rst_words", validDat.size(), 3);
        check("post_rst_dat2", validDat[2], 32'hFBFD0402);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

endmodule
